// File: rtl/jk_pkg.sv
// Shared types and per-bit JK excitation rule for the excitation driver.
// Latency: none (types and a pure function).
// Backpressure: not applicable.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    // {J,K} encodings of the four JK actions
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Returns {J,K} that moves one flip-flop from q to t. With xfill set the
    // don't-care input is driven high, so transitions turn into toggles and
    // holds become explicit set/reset.
    function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic xfill);
        logic [1:0] r_jk;
        case ({q, t})
            2'b00:   r_jk = xfill ? JK_RESET  : JK_HOLD;
            2'b01:   r_jk = xfill ? JK_TOGGLE : JK_SET;
            2'b10:   r_jk = xfill ? JK_TOGGLE : JK_RESET;
            default: r_jk = xfill ? JK_SET    : JK_HOLD;
        endcase
        return r_jk;
    endfunction

endpackage

// File: rtl/jk_excite_cell.sv
// Per-bit J/K excitation from current Q and target bit.
// Latency: purely combinational.
// Backpressure: none.
module jk_excite_cell
    import jk_pkg::*;
#(
    parameter bit XFILL = 1'b0
) (
    input  logic i_q,
    input  logic i_tgt,
    output logic o_j,
    output logic o_k
);

    logic [1:0] w_jk;

    assign w_jk = jk_excite(i_q, i_tgt, XFILL);
    assign o_j  = w_jk[1];
    assign o_k  = w_jk[0];

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK flip-flop bank to requested target words and verifies the result.
// Latency: 3 edges from accept to done pulse; one target every 3 cycles.
// Backpressure: o_tgt_ready low in DRIVE/CHECK; the source holds i_tgt_valid until accepted.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter bit XFILL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tgt_valid,
    output logic             o_tgt_ready,
    input  logic [WIDTH-1:0] i_tgt_data,
    input  logic [WIDTH-1:0] i_q_in,
    output logic [WIDTH-1:0] o_jk_j,
    output logic [WIDTH-1:0] o_jk_k,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [WIDTH-1:0] o_err_mask,
    output logic [CNT_W-1:0] o_err_count,
    input  logic             i_err_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_err_mask;
    logic [CNT_W-1:0] r_err_count;

    logic [WIDTH-1:0] w_exc_j;
    logic [WIDTH-1:0] w_exc_k;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_tgt_nxt;
    logic [WIDTH-1:0] w_j_nxt;
    logic [WIDTH-1:0] w_k_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_mask_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Excitation is taken from the live Q feedback at the accept edge.
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_excite_cell #(
            .XFILL (XFILL)
        ) u_cell (
            .i_q   (i_q_in[g]),
            .i_tgt (i_tgt_data[g]),
            .o_j   (w_exc_j[g]),
            .o_k   (w_exc_k[g])
        );
    end

    assign w_diff = i_q_in ^ r_tgt;

    // State register; reset parks the driver in IDLE.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt = r_state;
        w_tgt_nxt   = r_tgt;
        w_j_nxt     = '0;
        w_k_nxt     = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_mask_nxt  = r_err_mask;
        w_cnt_nxt   = r_err_count;
        case (r_state)
            IDLE: begin
                if (i_tgt_valid) begin
                    w_tgt_nxt   = i_tgt_data;
                    w_j_nxt     = w_exc_j;
                    w_k_nxt     = w_exc_k;
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                // bank samples J/K on this edge; they return to hold after it
                w_state_nxt = CHECK;
            end
            CHECK: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
                if (|w_diff) begin
                    w_err_nxt  = 1'b1;
                    w_mask_nxt = w_diff;
                    if (r_err_count != CNT_MAX) begin
                        w_cnt_nxt = r_err_count + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // clear wins over a coincident mismatch; the err pulse still goes out
        if (i_err_clr) begin
            w_mask_nxt = '0;
            w_cnt_nxt  = '0;
        end
    end

    // Registered outputs and latched target; reset drops J/K to hold at once.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tgt       <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_mask  <= '0;
            r_err_count <= '0;
        end else begin
            r_tgt       <= w_tgt_nxt;
            r_j         <= w_j_nxt;
            r_k         <= w_k_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_err_mask  <= w_mask_nxt;
            r_err_count <= w_cnt_nxt;
        end
    end

    assign o_tgt_ready = (r_state == IDLE);
    assign o_busy      = (r_state != IDLE);
    assign o_jk_j      = r_j;
    assign o_jk_k      = r_k;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_err_mask  = r_err_mask;
    assign o_err_count = r_err_count;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two drivers (minimal fill with 2-bit counter, toggle fill
// with 8-bit counter) share one stimulus, each driving its own JK plant bank.
// Outputs are sampled on the falling edge; inputs change there as well.
module tb_jk_excitation_driver;

    logic       clk;
    logic       rst_n;
    logic       tgt_valid;
    logic [3:0] tgt_data;
    logic       err_clr;
    logic [3:0] stuck;

    logic [3:0] q0, j0, k0, mask0;
    logic       rdy0, busy0, done0, err0;
    logic [1:0] cnt0;
    logic [3:0] q1, j1, k1, mask1;
    logic       rdy1, busy1, done1, err1;
    logic [7:0] cnt1;

    int n_assert;
    int n_fail;

    logic [3:0] tg   [3];
    logic [3:0] ej0  [3];
    logic [3:0] ek0  [3];
    logic [3:0] ej1  [3];
    logic [3:0] ek1  [3];

    jk_excitation_driver #(.WIDTH(4), .CNT_W(2), .XFILL(1'b0)) u_dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_tgt_valid(tgt_valid), .o_tgt_ready(rdy0),
        .i_tgt_data(tgt_data), .i_q_in(q0), .o_jk_j(j0), .o_jk_k(k0), .o_busy(busy0),
        .o_done(done0), .o_err(err0), .o_err_mask(mask0), .o_err_count(cnt0),
        .i_err_clr(err_clr)
    );

    jk_excitation_driver #(.WIDTH(4), .CNT_W(8), .XFILL(1'b1)) u_dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_tgt_valid(tgt_valid), .o_tgt_ready(rdy1),
        .i_tgt_data(tgt_data), .i_q_in(q1), .o_jk_j(j1), .o_jk_k(k1), .o_busy(busy1),
        .o_done(done1), .o_err(err1), .o_err_mask(mask1), .o_err_count(cnt1),
        .i_err_clr(err_clr)
    );

    // Plant: JK flip-flop banks; bits set in stuck are held at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0 <= '0;
            q1 <= '0;
        end else begin
            q0 <= ((j0 & ~q0) | (~k0 & q0)) & ~stuck;
            q1 <= ((j1 & ~q1) | (~k1 & q1)) & ~stuck;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Completion cycle: done pulse plus error state on both drivers.
    task automatic check_done(input string tag, input logic e, input logic [31:0] c0,
                              input logic [31:0] c1, input logic [3:0] m);
        check({tag, ".done0"}, done0, 1);
        check({tag, ".done1"}, done1, 1);
        check({tag, ".err0"},  err0,  e);
        check({tag, ".err1"},  err1,  e);
        check({tag, ".cnt0"},  cnt0,  c0);
        check({tag, ".cnt1"},  cnt1,  c1);
        check({tag, ".mask0"}, mask0, m);
        check({tag, ".mask1"}, mask1, m);
        check({tag, ".rdy0"},  rdy0,  1);
        check({tag, ".busy1"}, busy1, 0);
    endtask

    // Present one target in IDLE; returns at the falling edge inside DRIVE.
    task automatic start(input logic [3:0] t);
        tgt_valid = 1'b1;
        tgt_data  = t;
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0; tgt_valid = 1'b0; tgt_data = '0; err_clr = 1'b0; stuck = '0;
        tg[0]  = 4'b0011; tg[1]  = 4'b1100; tg[2]  = 4'b1111;
        ej0[0] = 4'b0011; ej0[1] = 4'b1100; ej0[2] = 4'b0011;
        ek0[0] = 4'b0000; ek0[1] = 4'b0011; ek0[2] = 4'b0000;
        ej1[0] = 4'b0011; ej1[1] = 4'b1111; ej1[2] = 4'b1111;
        ek1[0] = 4'b1111; ek1[1] = 4'b1111; ek1[2] = 4'b0011;

        // reset state
        repeat (2) @(negedge clk);
        check("rst.j0", j0, 0);     check("rst.k0", k0, 0);
        check("rst.j1", j1, 0);     check("rst.k1", k1, 0);
        check("rst.done0", done0, 0); check("rst.err0", err0, 0);
        check("rst.mask0", mask0, 0); check("rst.cnt0", cnt0, 0);
        check("rst.busy0", busy0, 0); check("rst.cnt1", cnt1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel.rdy0", rdy0, 1); check("rel.rdy1", rdy1, 1);

        // 1: reset pulsed mid-DRIVE drops J/K asynchronously, no done
        start(4'b1111);
        check("t1.j0", j0, 4'b1111); check("t1.k0", k0, 4'b0000);
        check("t1.j1", j1, 4'b1111); check("t1.k1", k1, 4'b1111);
        check("t1.busy0", busy0, 1); check("t1.rdy0", rdy0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("t1.async_j0", j0, 0); check("t1.async_k0", k0, 0);
        check("t1.async_j1", j1, 0); check("t1.async_k1", k1, 0);
        check("t1.async_busy0", busy0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t1.nodone0", done0, 0); check("t1.nodone1", done1, 0);
        end
        check("t1.cnt0", cnt0, 0); check("t1.rdy0", rdy0, 1); check("t1.q0", q0, 0);

        // 2: 0000 -> 1010
        start(4'b1010);
        check("t2.j0", j0, 4'b1010); check("t2.k0", k0, 4'b0000);
        check("t2.j1", j1, 4'b1010); check("t2.k1", k1, 4'b1111);
        check("t2.rdy0", rdy0, 0);
        @(negedge clk);
        check("t2.chk_j0", j0, 0);   check("t2.chk_k1", k1, 0);
        check("t2.q0", q0, 4'b1010); check("t2.q1", q1, 4'b1010);
        check("t2.chk_busy0", busy0, 1); check("t2.chk_rdy0", rdy0, 0);
        check("t2.chk_done0", done0, 0);
        @(negedge clk);
        check_done("t2", 1'b0, 0, 0, 4'b0000);

        // 3: 1010 -> 0110, minimal vs toggle-preferring fill
        start(4'b0110);
        check("t3.j0", j0, 4'b0100); check("t3.k0", k0, 4'b1000);
        check("t3.j1", j1, 4'b1110); check("t3.k1", k1, 4'b1101);
        @(negedge clk);
        check("t3.q0", q0, 4'b0110); check("t3.q1", q1, 4'b0110);
        @(negedge clk);
        check_done("t3", 1'b0, 0, 0, 4'b0000);

        // 4: bit 0 stuck at 0, target 0001
        stuck = 4'b0001;
        start(4'b0001);
        @(negedge clk);
        check("t4.q0", q0, 4'b0000);
        @(negedge clk);
        check_done("t4", 1'b1, 1, 1, 4'b0001);
        @(negedge clk);
        check("t4.done0_low", done0, 0); check("t4.err0_low", err0, 0);
        check("t4.mask0_held", mask0, 4'b0001);
        stuck = 4'b0000;

        // 5: back-to-back targets with tgt_valid held high
        tgt_valid = 1'b1;
        tgt_data  = tg[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5.j0", j0, ej0[i]); check("t5.k0", k0, ek0[i]);
            check("t5.j1", j1, ej1[i]); check("t5.k1", k1, ek1[i]);
            check("t5.drv_rdy0", rdy0, 0);
            if (i < 2) tgt_data = tg[i+1];
            else       tgt_valid = 1'b0;
            @(negedge clk);
            check("t5.chk_rdy0", rdy0, 0); check("t5.chk_rdy1", rdy1, 0);
            check("t5.q0", q0, tg[i]);  check("t5.q1", q1, tg[i]);
            @(negedge clk);
            check_done("t5", 1'b0, 1, 1, 4'b0001);
        end

        // 6: standalone clear, saturation, clear coincident with a mismatch
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t6.clr_cnt0", cnt0, 0);   check("t6.clr_cnt1", cnt1, 0);
        check("t6.clr_mask0", mask0, 0); check("t6.clr_mask1", mask1, 0);
        stuck = 4'b0001;
        for (int n = 1; n <= 5; n++) begin
            start(4'b0001);
            @(negedge clk);
            @(negedge clk);
            check_done("t6.sat", 1'b1, (n < 3) ? n : 3, n, 4'b0001);
        end
        start(4'b0001);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_done("t6.clr_err", 1'b1, 0, 0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
